// File: rtl/updn_counter_gen_pkg.sv
// Shared types, default parameters and the next-value arithmetic for the
// parametrised up/down counter.
package counter_gen_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } cnt_mode_e;

    localparam int WIDTH_DEF   = 8;
    localparam int STEP_W_DEF  = 8;
    localparam int PRESC_W_DEF = 8;

    // Arithmetic is done at a fixed 32-bit width; callers zero-extend and truncate.
    localparam int CALC_W = 32;

    typedef struct packed {
        logic [CALC_W-1:0] value;
        logic              ovf;
        logic              unf;
    } next_cnt_t;

    function automatic next_cnt_t next_count(
        input logic [CALC_W-1:0] cur,
        input logic [CALC_W-1:0] step,
        input logic [CALC_W-1:0] max,
        input logic              up,
        input cnt_mode_e         mode
    );
        next_cnt_t   r;
        logic [33:0] sum;
        logic [33:0] span;
        r.value = cur;
        r.ovf   = 1'b0;
        r.unf   = 1'b0;
        sum     = '0;
        span    = {2'b00, max} + 34'd1;
        if (step != '0) begin
            if (cur > max) begin
                // Limit was lowered underneath the count.
                if (up) begin
                    r.ovf   = 1'b1;
                    r.value = (mode == MODE_SAT) ? max : '0;
                end else begin
                    r.value = max;
                end
            end else if (up) begin
                sum = {2'b00, cur} + {2'b00, step};
                if (sum <= {2'b00, max}) begin
                    r.value = sum[CALC_W-1:0];
                end else begin
                    r.ovf = 1'b1;
                    if (mode == MODE_SAT) begin
                        r.value = max;
                    end else begin
                        sum     = sum - span;
                        r.value = (sum > {2'b00, max}) ? max : sum[CALC_W-1:0];
                    end
                end
            end else if (step <= cur) begin
                r.value = cur - step;
            end else begin
                r.unf = 1'b1;
                if (mode == MODE_SAT) begin
                    r.value = '0;
                end else begin
                    sum = {2'b00, cur} + span;
                    if ({2'b00, step} > sum) begin
                        r.value = max;
                    end else begin
                        sum     = sum - {2'b00, step};
                        r.value = (sum > {2'b00, max}) ? max : sum[CALC_W-1:0];
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/updn_counter_gen_if.sv
// Control and status bundle of the up/down counter; master drives controls,
// slave (the counter) drives the count and flags.
interface updn_counter_gen_if #(
    parameter int WIDTH   = 8,
    parameter int STEP_W  = 8,
    parameter int PRESC_W = 8
);
    logic               en_ctrl_in;
    logic               set_ctrl_in;
    logic               up_ctrl_in;
    logic               sat_ctrl_in;
    logic [STEP_W-1:0]  step_in;
    logic [WIDTH-1:0]   counter_in;
    logic [WIDTH-1:0]   max_in;
    logic [PRESC_W-1:0] presc_in;
    logic               clr_flags_in;
    logic [WIDTH-1:0]   counter_out;
    logic               ovf_out;
    logic               unf_out;
    logic               tc_out;
    logic               ovf_sticky_out;
    logic               unf_sticky_out;

    modport master (
        output en_ctrl_in, set_ctrl_in, up_ctrl_in, sat_ctrl_in, step_in,
               counter_in, max_in, presc_in, clr_flags_in,
        input  counter_out, ovf_out, unf_out, tc_out, ovf_sticky_out, unf_sticky_out
    );

    modport slave (
        input  en_ctrl_in, set_ctrl_in, up_ctrl_in, sat_ctrl_in, step_in,
               counter_in, max_in, presc_in, clr_flags_in,
        output counter_out, ovf_out, unf_out, tc_out, ovf_sticky_out, unf_sticky_out
    );
endinterface

// File: rtl/updn_counter_gen_prescaler.sv
// Tick prescaler: one tick every presc_in+1 enabled cycles, cleared by clr.
module counter_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc_in,
    output logic               tick_out
);
    logic [PRESC_W-1:0] count_q;
    logic [PRESC_W-1:0] count_d;

    always_comb begin
        tick_out = en && !clr && (count_q == presc_in);
        count_d  = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tick_out ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/updn_counter_gen.sv
// Parametrised up/down counter with modulo limit, programmable step, wrap or
// saturate mode, prescaled ticks and overflow/underflow pulse and sticky flags.
module updn_counter_gen
    import counter_gen_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int STEP_W  = STEP_W_DEF,
    parameter int PRESC_W = PRESC_W_DEF
) (
    input logic          clk_in,
    input logic          rst_in,
    updn_counter_gen_if.slave bus
);
    logic [WIDTH-1:0] counter_q, counter_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic             unf_sticky_q, unf_sticky_d;
    logic             tick;
    next_cnt_t        nc;
    cnt_mode_e        mode;

    counter_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .en       (bus.en_ctrl_in),
        .clr      (bus.set_ctrl_in),
        .presc_in (bus.presc_in),
        .tick_out (tick)
    );

    always_comb begin
        mode = bus.sat_ctrl_in ? MODE_SAT : MODE_WRAP;
        nc   = next_count(CALC_W'(counter_q), CALC_W'(bus.step_in), CALC_W'(bus.max_in),
                          bus.up_ctrl_in, mode);
        counter_d = counter_q;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        if (bus.set_ctrl_in) begin
            counter_d = (bus.counter_in > bus.max_in) ? bus.max_in : bus.counter_in;
        end else if (tick) begin
            counter_d = nc.value[WIDTH-1:0];
            ovf_d     = nc.ovf;
            unf_d     = nc.unf;
        end
        // An event in the same cycle as a clear keeps the flag set.
        ovf_sticky_d = ovf_d | (ovf_sticky_q & ~bus.clr_flags_in);
        unf_sticky_d = unf_d | (unf_sticky_q & ~bus.clr_flags_in);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            counter_q    <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            ovf_sticky_q <= 1'b0;
            unf_sticky_q <= 1'b0;
        end else begin
            counter_q    <= counter_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
            ovf_sticky_q <= ovf_sticky_d;
            unf_sticky_q <= unf_sticky_d;
        end
    end

    assign bus.counter_out    = counter_q;
    assign bus.ovf_out        = ovf_q;
    assign bus.unf_out        = unf_q;
    assign bus.ovf_sticky_out = ovf_sticky_q;
    assign bus.unf_sticky_out = unf_sticky_q;
    assign bus.tc_out         = (counter_q == (bus.up_ctrl_in ? bus.max_in : '0));
endmodule

// File: tb/tb_updn_counter_gen.sv
// Directed bench for updn_counter_gen at WIDTH=8 with hand-computed expectations.
module tb_updn_counter_gen;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    updn_counter_gen_if #(.WIDTH(8), .STEP_W(8), .PRESC_W(8)) bus ();

    updn_counter_gen #(.WIDTH(8), .STEP_W(8), .PRESC_W(8)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Illegal programming guard: step may not exceed max_in+1 while counting.
    always @(negedge clk) begin
        if (!rst && bus.en_ctrl_in && !bus.set_ctrl_in) begin
            assert ({1'b0, bus.step_in} <= {1'b0, bus.max_in} + 9'd1)
            else begin
                errors++;
                $error("FAIL illegal_step: step %0h max %0h", bus.step_in, bus.max_in);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.en_ctrl_in   = 1'b0;
        bus.set_ctrl_in  = 1'b0;
        bus.up_ctrl_in   = 1'b0;
        bus.sat_ctrl_in  = 1'b0;
        bus.step_in      = 8'd0;
        bus.counter_in   = 8'd0;
        bus.max_in       = 8'd0;
        bus.presc_in     = 8'd0;
        bus.clr_flags_in = 1'b0;
        edges(2);
        chk("init_count", 32'(bus.counter_out), 32'h0);
        chk("init_tc", 32'(bus.tc_out), 32'h1);

        // Reset mid-count at 0x37 with enable active
        rst = 1'b0;
        bus.max_in = 8'hFF;
        bus.counter_in = 8'h37;
        bus.set_ctrl_in = 1'b1;
        edges(1);
        chk("load_37", 32'(bus.counter_out), 32'h37);
        bus.set_ctrl_in = 1'b0;
        bus.up_ctrl_in = 1'b1;
        bus.step_in = 8'd1;
        bus.en_ctrl_in = 1'b1;
        rst = 1'b1;
        edges(1);
        chk("rst_count_1", 32'(bus.counter_out), 32'h0);
        edges(1);
        chk("rst_count_2", 32'(bus.counter_out), 32'h0);
        chk("rst_flags", {28'h0, bus.ovf_out, bus.unf_out, bus.ovf_sticky_out, bus.unf_sticky_out}, 32'h0);
        rst = 1'b0;
        bus.en_ctrl_in = 1'b0;

        // Wrap up: max 9, step 3, 8 -> 1 with ovf, then 4
        bus.max_in = 8'd9;
        bus.step_in = 8'd3;
        bus.sat_ctrl_in = 1'b0;
        bus.counter_in = 8'd8;
        bus.set_ctrl_in = 1'b1;
        edges(1);
        chk("wrap_load", 32'(bus.counter_out), 32'd8);
        bus.set_ctrl_in = 1'b0;
        bus.en_ctrl_in = 1'b1;
        edges(1);
        chk("wrap_val", 32'(bus.counter_out), 32'd1);
        chk("wrap_ovf", {30'h0, bus.ovf_out, bus.ovf_sticky_out}, 32'h3);
        edges(1);
        chk("wrap_next", 32'(bus.counter_out), 32'd4);
        chk("wrap_next_ovf", {30'h0, bus.ovf_out, bus.ovf_sticky_out}, 32'h1);
        bus.en_ctrl_in = 1'b0;

        // Saturate down: max 255, 2 - 5 -> 0 with unf, repeated
        bus.max_in = 8'hFF;
        bus.sat_ctrl_in = 1'b1;
        bus.up_ctrl_in = 1'b0;
        bus.step_in = 8'd5;
        bus.counter_in = 8'd2;
        bus.set_ctrl_in = 1'b1;
        edges(1);
        bus.set_ctrl_in = 1'b0;
        bus.en_ctrl_in = 1'b1;
        edges(1);
        chk("sat_dn_val", 32'(bus.counter_out), 32'd0);
        chk("sat_dn_unf", {30'h0, bus.unf_out, bus.unf_sticky_out}, 32'h3);
        edges(1);
        chk("sat_dn_again", {23'h0, bus.counter_out, bus.unf_out}, 32'h1);
        chk("sat_dn_tc", 32'(bus.tc_out), 32'h1);
        bus.en_ctrl_in = 1'b0;
        edges(1);
        chk("sat_dn_idle", 32'(bus.unf_out), 32'h0);

        // Prescaler: presc 3, count every 4th enabled cycle, freeze with en=0
        bus.presc_in = 8'd3;
        bus.step_in = 8'd1;
        bus.up_ctrl_in = 1'b1;
        bus.sat_ctrl_in = 1'b0;
        bus.counter_in = 8'd0;
        bus.set_ctrl_in = 1'b1;
        edges(1);
        bus.set_ctrl_in = 1'b0;
        bus.en_ctrl_in = 1'b1;
        edges(3);
        chk("presc_3", 32'(bus.counter_out), 32'd0);
        edges(1);
        chk("presc_4", 32'(bus.counter_out), 32'd1);
        edges(2);
        bus.en_ctrl_in = 1'b0;
        edges(5);
        chk("presc_frozen", 32'(bus.counter_out), 32'd1);
        bus.en_ctrl_in = 1'b1;
        edges(1);
        chk("presc_resume_1", 32'(bus.counter_out), 32'd1);
        edges(1);
        chk("presc_resume_2", 32'(bus.counter_out), 32'd2);
        bus.en_ctrl_in = 1'b0;
        bus.presc_in = 8'd0;

        // Priority/clamp: set beats tick, load clamps to max; lowered max in sat mode
        bus.max_in = 8'd100;
        bus.counter_in = 8'd200;
        bus.sat_ctrl_in = 1'b1;
        bus.set_ctrl_in = 1'b1;
        bus.en_ctrl_in = 1'b1;
        edges(1);
        chk("clamp_val", 32'(bus.counter_out), 32'd100);
        chk("clamp_no_ovf", 32'(bus.ovf_out), 32'h0);
        bus.set_ctrl_in = 1'b0;
        bus.max_in = 8'd50;
        edges(1);
        chk("lowered_val", 32'(bus.counter_out), 32'd50);
        chk("lowered_ovf", 32'(bus.ovf_out), 32'h1);
        chk("lowered_tc", 32'(bus.tc_out), 32'h1);
        bus.en_ctrl_in = 1'b0;

        // Sticky race: clear together with an overflow keeps the flag
        bus.clr_flags_in = 1'b1;
        edges(1);
        chk("clr_both", {30'h0, bus.ovf_sticky_out, bus.unf_sticky_out}, 32'h0);
        bus.clr_flags_in = 1'b0;
        bus.max_in = 8'd9;
        bus.step_in = 8'd3;
        bus.sat_ctrl_in = 1'b0;
        bus.counter_in = 8'd8;
        bus.set_ctrl_in = 1'b1;
        edges(1);
        bus.set_ctrl_in = 1'b0;
        bus.en_ctrl_in = 1'b1;
        bus.clr_flags_in = 1'b1;
        edges(1);
        chk("race_val", 32'(bus.counter_out), 32'd1);
        chk("race_sticky", 32'(bus.ovf_sticky_out), 32'h1);
        bus.en_ctrl_in = 1'b0;
        edges(1);
        chk("clr_alone", 32'(bus.ovf_sticky_out), 32'h0);
        bus.clr_flags_in = 1'b0;

        // Zero step holds without pulses
        bus.step_in = 8'd0;
        bus.en_ctrl_in = 1'b1;
        edges(1);
        chk("step0_val", {23'h0, bus.counter_out, bus.ovf_out}, {23'h0, 8'd1, 1'b0});
        bus.en_ctrl_in = 1'b0;

        // Down tick with max lowered below count snaps to max, no pulse
        bus.counter_in = 8'd9;
        bus.set_ctrl_in = 1'b1;
        edges(1);
        bus.set_ctrl_in = 1'b0;
        bus.max_in = 8'd4;
        bus.up_ctrl_in = 1'b0;
        bus.step_in = 8'd1;
        bus.en_ctrl_in = 1'b1;
        edges(1);
        chk("lowered_dn_val", 32'(bus.counter_out), 32'd4);
        chk("lowered_dn_unf", 32'(bus.unf_out), 32'h0);
        bus.en_ctrl_in = 1'b0;
        edges(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/updn_counter_gen.md
Name: updn_counter_gen

Overview:
Parametrised up/down counter, successor to the fixed 8-bit enable/set/up counter. It adds generic width, a programmable modulo limit, a programmable step, and a selectable wrap or saturate mode. It also adds a tick prescaler, separate overflow/underflow pulses with sticky flags, and a terminal-count flag. It is a standalone leaf block with its own UVM agent and env reuse, used wherever the design needs a timer, event counter or address sequencer.

Parameters:
WIDTH, 8, counter, load and limit width
STEP_W, 8, step_in width (STEP_W <= WIDTH)
PRESC_W, 8, prescaler compare width

Ports:
clk_in  in  1  clock, all logic on rising edge
rst_in  in  1  reset, synchronous, active-high
en_ctrl_in  in  1  count enable
set_ctrl_in  in  1  load counter_in
up_ctrl_in  in  1  1 = count up, 0 = count down
sat_ctrl_in  in  1  1 = saturate at bounds, 0 = wrap modulo (max_in+1)
step_in  in  STEP_W  increment/decrement per tick
counter_in  in  WIDTH  load value
max_in  in  WIDTH  upper bound; range is 0..max_in
presc_in  in  PRESC_W  tick every presc_in+1 enabled cycles
clr_flags_in  in  1  clear sticky flags
counter_out  out  WIDTH  registered count
ovf_out  out  1  registered 1-cycle pulse, upper bound crossed
unf_out  out  1  registered 1-cycle pulse, lower bound crossed
tc_out  out  1  comb: counter_out == (up_ctrl_in ? max_in : 0)
ovf_sticky_out  out  1  sticky overflow
unf_sticky_out  out  1  sticky underflow

Behaviour:
- Reset: synchronous, active-high, highest priority.
  - counter_out, prescaler count, ovf_out, unf_out and both sticky flags are 0.
  - tc_out follows its equation.
- Priority after reset: set > tick > hold.
- Set: counter_out <= min(counter_in, max_in) next cycle.
  - The prescaler count clears.
  - No ovf/unf pulse.
- Prescaler:
  - Counts only while en_ctrl_in=1 and set=0; holds when en=0.
  - Tick is asserted when prescaler count == presc_in; the count then returns to 0.
  - presc_in=0 gives a tick every enabled cycle.
- Tick, up, with S = counter + step computed in WIDTH+1 bits:
  - S <= max_in: counter <= S.
  - S > max_in: ovf pulse. Wrap mode: counter <= S - (max_in+1). Sat mode: counter <= max_in.
- Tick, down:
  - step <= counter: counter <= counter - step.
  - Otherwise unf pulse. Wrap mode: counter <= counter + (max_in+1) - step. Sat mode: counter <= 0.
- Pulses repeat on every tick that crosses a bound, including a saturated counter receiving further ticks.
- step_in = 0: tick holds the value, no pulses.
- max_in lowered below the current count:
  - Up tick: treated as overflow (wrap -> 0, sat -> max_in).
  - Down tick: counter <= max_in, no pulse.
- step_in > max_in+1 is illegal. The bench assertion fires; RTL clamps the wrap result to max_in.
- Sticky flags:
  - Set on their pulse.
  - Cleared by clr_flags_in.
  - Set wins if a clear and an event occur in the same cycle.
- Latency: one cycle from the tick/set edge to counter_out and the pulses.

Decomposition:
- counter_gen_pkg holds:
  - typedef enum {MODE_WRAP, MODE_SAT} cnt_mode_e
  - default parameter constants
  - the next-value function next_count(cur, step, max, up, sat), returning value and ovf/unf flags
- One sub-module, counter_prescaler (PRESC_W; ports clk_in, rst_in, en, clr, presc_in, tick_out).

Test Plan (WIDTH=8):
- Reset: rst_in=1 for 2 cycles mid-count at 0x37 -> counter_out=0, all flags 0 on the following edge.
- Wrap up: max=9, step=3, set to 8, then en, up, wrap -> 8 -> 1 with ovf_out pulse, ovf_sticky_out=1; next tick -> 4, no pulse.
- Saturate down: max=255, set to 2, step=5, down, sat -> 0 with unf_out pulse; second tick stays 0 with another unf pulse; tc_out=1.
- Prescaler: presc_in=3, step=1, up from 0 -> counter_out increments every 4th enabled cycle; en=0 for 5 cycles freezes both count and prescaler.
- Priority/clamp: set=1 and en=1 same cycle, counter_in=200, max=100 -> counter_out=100, no pulse; max lowered to 50 then up tick in sat mode -> 50 with ovf.
- Sticky race: clr_flags_in=1 in the same cycle as an overflow tick -> ovf_sticky_out remains 1; clear alone next cycle -> 0.
